// File: rtl/hera_pkg.sv
// Shared HERA types: LSU FSM states, register index, data word, default offset width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hera_pkg;

    typedef enum logic [1:0] {
        LSU_IDLE   = 2'd0,
        LSU_ACCESS = 2'd1,
        LSU_RESP   = 2'd2
    } lsu_state_t;

    typedef logic [3:0]  reg_idx_t;
    typedef logic [15:0] word_t;

    localparam int OFF_W_DEF = 5;

endpackage

// File: rtl/hera_lsu_agen.sv
// Effective-address adder: base + zero-extended unsigned offset, truncated to ADDR_W.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   base   - base register value (BASE_W bits)
//   offset - unsigned instruction offset (OFF_W bits)
//   addr   - (base + offset) mod 2^ADDR_W, wraps silently
module hera_lsu_agen #(
    parameter int BASE_W = 16,
    parameter int OFF_W  = 5,
    parameter int ADDR_W = 16
) (
    input  logic [BASE_W-1:0] base,
    input  logic [OFF_W-1:0]  offset,
    output logic [ADDR_W-1:0] addr
);

    logic [BASE_W-1:0] sum;

    // Carry out of the top bit is discarded on purpose: address space wraps.
    assign sum  = base + BASE_W'(offset);
    assign addr = sum[ADDR_W-1:0];

endmodule

// File: rtl/hera_lsu.sv
// Load/store unit feeding the HERA register file over a req/ack data-memory port.
// Latency: strobe to load_en = 2 cycles + memory wait cycles; stores retire on ack.
// Backpressure: stall held in the request cycle and all of ACCESS; strobes outside IDLE are ignored.
//
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   ld_en, st_en              - issue strobes (load wins if both are high)
//   base, offset, st_data     - address operands and store data
//   rd_in                     - load destination index
//   load_en, load, load_rd    - one-cycle load writeback to the register file
//   stall                     - pipeline hold request
//   err                       - sticky access-abort flag
//   mem_req, mem_we, mem_addr, mem_wdata, mem_ack, mem_rdata - data-memory port
//
// Optional feature: define HERA_LSU_TIMEOUT_EN to abort an access after TIMEOUT
// ACCESS cycles without mem_ack (sets err). Undefined: ACCESS waits forever, err = 0.
module hera_lsu
    import hera_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int OFF_W   = OFF_W_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_en,
    input  logic              st_en,
    input  logic [15:0]       base,
    input  logic [OFF_W-1:0]  offset,
    input  logic [15:0]       st_data,
    input  logic [3:0]        rd_in,
    output logic              load_en,
    output logic [15:0]       load,
    output logic [3:0]        load_rd,
    output logic              stall,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata
);

    lsu_state_t        state;
    lsu_state_t        state_nxt;
    logic [ADDR_W-1:0] ea;
    logic              issue;
    logic              timeout_hit;
    word_t             load_q;
    reg_idx_t          rd_q;

    hera_lsu_agen #(
        .BASE_W (16),
        .OFF_W  (OFF_W),
        .ADDR_W (ADDR_W)
    ) u_agen (
        .base   (base),
        .offset (offset),
        .addr   (ea)
    );

    assign issue = (state == LSU_IDLE) && (ld_en || st_en);

    // ------------------------------------------------------------------
    // Optional access timeout
    // ------------------------------------------------------------------
`ifdef HERA_LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] to_cnt;
    logic             err_q;

    // An ack arriving in the final allowed cycle still wins over the abort.
    assign timeout_hit = (state == LSU_ACCESS) && !mem_ack &&
                         (to_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state != LSU_ACCESS) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    // Parameter kept so both builds share one parameter list.
    localparam int unused_timeout = TIMEOUT;

    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LSU_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        mem_req   = 1'b0;
        load_en   = 1'b0;
        unique case (state)
            LSU_IDLE: begin
                if (issue) begin
                    stall     = 1'b1;
                    state_nxt = LSU_ACCESS;
                end
            end
            LSU_ACCESS: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                if (mem_ack) begin
                    state_nxt = mem_we ? LSU_IDLE : LSU_RESP;
                end else if (timeout_hit) begin
                    state_nxt = LSU_IDLE;
                end
            end
            LSU_RESP: begin
                // Strobes seen here are deliberately dropped; upstream reissues in IDLE.
                load_en   = 1'b1;
                state_nxt = LSU_IDLE;
            end
            default: begin
                state_nxt = LSU_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: request fields are captured at issue and held through ACCESS.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            rd_q      <= '0;
            load_q    <= '0;
        end else begin
            if (issue) begin
                mem_addr  <= ea;
                mem_we    <= st_en & ~ld_en;
                mem_wdata <= st_data;
                rd_q      <= rd_in;
            end
            if ((state == LSU_ACCESS) && mem_ack && !mem_we) begin
                load_q <= mem_rdata;
            end
        end
    end

    assign load    = load_q;
    assign load_rd = rd_q;

endmodule

// File: tb/tb_hera_lsu.sv
module tb_hera_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_en;
    logic        st_en;
    logic [15:0] base;
    logic [4:0]  offset;
    logic [15:0] st_data;
    logic [3:0]  rd_in;
    logic        load_en;
    logic [15:0] load;
    logic [3:0]  load_rd;
    logic        stall;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    int tests = 0;
    int fails = 0;
    logic [15:0] last_load = 16'h0;

    hera_lsu dut (
        .clk       (clk),
        .rst       (rst),
        .ld_en     (ld_en),
        .st_en     (st_en),
        .base      (base),
        .offset    (offset),
        .st_data   (st_data),
        .rd_in     (rd_in),
        .load_en   (load_en),
        .load      (load),
        .load_rd   (load_rd),
        .stall     (stall),
        .err       (err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Move to the drive point of the next cycle (1 time unit after the edge).
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One LOAD/STORE transaction. Entered at the drive point of an IDLE cycle;
    // leaves at the sample point of the first IDLE cycle after completion.
    // n_acc = number of ACCESS cycles (ack arrives in the last one).
    task automatic run_op(input bit ld, input bit st, input logic [15:0] b,
                          input logic [4:0] off, input logic [15:0] wd,
                          input logic [3:0] rd, input int n_acc,
                          input logic [15:0] rdat, input bit keep_ld);
        int   exp_addr;
        bit   exp_we;
        bit   is_load;
        int   stall_cnt;
        int   acc;
        int   pulses;
        int   cyc;
        bit   acked;
        exp_addr  = (int'(b) + int'(off)) % 65536;
        is_load   = ld;
        exp_we    = !is_load;
        stall_cnt = 0;
        acc       = 0;
        pulses    = 0;
        cyc       = 0;
        acked     = 1'b0;
        ld_en = ld; st_en = st; base = b; offset = off; st_data = wd; rd_in = rd;
        #1;
        check("req_cycle_stall", stall, 1);
        check("req_cycle_no_mem_req", mem_req, 0);
        while (stall && cyc < 64) begin
            stall_cnt++;
            if (mem_req) begin
                acc++;
                check("mem_addr", mem_addr, exp_addr);
                check("mem_we", mem_we, exp_we);
                if (exp_we) check("mem_wdata", mem_wdata, wd);
                if (acc == n_acc) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdat;
                    acked     = 1'b1;
                end
            end
            tick();
            mem_ack   = 1'b0;
            mem_rdata = 16'($urandom);
            // Upstream holds its inputs only while stalled.
            if (acked && !(keep_ld && is_load)) begin
                ld_en = 1'b0;
                st_en = 1'b0;
            end
            #1;
            if (load_en) pulses++;
            cyc++;
        end
        check("stall_cycles", stall_cnt, 1 + n_acc);
        check("access_cycles", acc, n_acc);
        if (is_load) begin
            last_load = rdat;
            check("resp_load_en", load_en, 1);
            check("resp_load", load, rdat);
            check("resp_load_rd", load_rd, rd);
            check("resp_no_mem_req", mem_req, 0);
            tick();
            if (!keep_ld) begin
                #1;
            end else begin
                ld_en = 1'b0;
                #1;
                ld_en = 1'b1;
            end
            if (load_en) pulses++;
            check("load_en_pulses", pulses, 1);
            check("load_hold", load, last_load);
        end else begin
            check("store_no_load_en", load_en, 0);
            check("store_load_en_pulses", pulses, 0);
            check("load_hold_after_store", load, last_load);
        end
    endtask

    initial begin
        rst = 1'b1; ld_en = 1'b0; st_en = 1'b0; base = '0; offset = '0;
        st_data = '0; rd_in = '0; mem_ack = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_load_en", load_en, 0);
        check("rst_load", load, 0);
        check("rst_load_rd", load_rd, 0);
        check("rst_stall", stall, 0);
        check("rst_err", err, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);

        // Load, 3 ACCESS cycles -> stall high 4 cycles.
        tick();
        run_op(1, 0, 16'h1000, 5'd5, 16'h0, 4'd4, 3, 16'hBEEF, 0);

        // Store, immediate ack.
        tick();
        run_op(0, 1, 16'h0020, 5'h1F, 16'h1234, 4'd0, 1, 16'h0, 0);

        // Wrap-around address.
        tick();
        run_op(1, 0, 16'hFFFF, 5'd3, 16'h0, 4'd7, 2, 16'h5A5A, 0);

        // Both strobes: read only; ld_en held through RESP is accepted in IDLE only.
        tick();
        run_op(1, 1, 16'h0100, 5'd1, 16'hDEAD, 4'd2, 1, 16'hC0DE, 1);
        check("b2b_reissue_stall", stall, 1);
        check("b2b_not_accepted_in_resp", mem_req, 0);
        run_op(1, 0, 16'h0100, 5'd1, 16'hDEAD, 4'd3, 2, 16'h7777, 0);

        // Reset while mem_req is high; a late ack is ignored.
        tick();
        ld_en = 1'b1; base = 16'h2000; offset = 5'd9; rd_in = 4'd9;
        tick();
        check("pre_rst_mem_req", mem_req, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0; ld_en = 1'b0;
        #1;
        check("post_rst_mem_req", mem_req, 0);
        check("post_rst_stall", stall, 0);
        mem_ack = 1'b1; mem_rdata = 16'hFACE;
        tick();
        mem_ack = 1'b0;
        #1;
        check("late_ack_no_load_en", load_en, 0);
        check("late_ack_no_mem_req", mem_req, 0);
        tick();
        check("late_ack_no_load_en2", load_en, 0);
        check("late_ack_load_unchanged", load, 0);
        last_load = 16'h0;

        // Randomized transactions against the transaction-level model.
        for (int i = 0; i < 25; i++) begin
            bit ld_r;
            bit st_r;
            ld_r = 1'($urandom);
            st_r = ld_r ? 1'($urandom) : 1'b1;
            tick();
            run_op(ld_r, st_r, 16'($urandom), 5'($urandom), 16'($urandom),
                   4'($urandom), int'($urandom_range(1, 4)), 16'($urandom), 0);
        end
        check("final_err", err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
